// File: rtl/mul_wb_pkg.sv
// Shared types for the multiply/adder write-back packer: FSM state encoding and word width.
package mul_wb_pkg;

    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with occupancy count; push while full and pop while empty are dropped.
module wb_fifo
    import mul_wb_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset: only entries behind the count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_wb_packer.sv
// Write-back packer: buffers 4x16-bit result words and streams them as sequential BRAM writes.
// Optional per-lane modulo-2^Q_BITS mask is enabled by defining WB_MOD_MASK_EN.
module mul_wb_packer
    import mul_wb_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int LANES       = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_STRIDE = 8,
    parameter int Q_BITS      = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [31:0]                   base_addr,
    input  logic [31:0]                   total_words,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH*LANES-1:0]   in_data,
    output logic                          in_ready,
    input  logic                          bram_gnt,
    output logic [31:0]                   bram_addr,
    output logic                          bram_wen,
    output logic [DATA_WIDTH*LANES-1:0]   bram_wdata,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    state_dbg
);

    localparam int W  = DATA_WIDTH * LANES;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wb_state_t      state;
    wb_state_t      state_next;
    logic [31:0]    total;
    logic [31:0]    accepted;
    logic [31:0]    written;
    logic [31:0]    wr_addr;
    logic [W-1:0]   push_data;
    logic [W-1:0]   fifo_head;
    logic [CW-1:0]  fifo_level;
    logic           fifo_empty;
    logic           unused_fifo_full;
    logic           push;
    logic           pop;

    assign state_dbg = state;

    // Valid/ready: a beat transfers on a rising edge where in_valid && in_ready are both high.
    // in_ready never looks at a same-cycle pop, so a full FIFO always stalls the source.
    assign in_ready = (state == RUN) && (fifo_level < CW'(FIFO_DEPTH)) && (accepted < total);
    assign push     = in_valid && in_ready;
    assign pop      = ((state == RUN) || (state == DRAIN)) && !fifo_empty && bram_gnt;

`ifdef WB_MOD_MASK_EN
    localparam logic [DATA_WIDTH-1:0] LANE_MASK = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - Q_BITS);

    for (genvar i = 0; i < LANES; i++) begin : g_lane_mask
        assign push_data[i*DATA_WIDTH +: DATA_WIDTH] = in_data[i*DATA_WIDTH +: DATA_WIDTH] & LANE_MASK;
    end
`else
    localparam int unused_q_bits = Q_BITS;

    assign push_data = in_data;
`endif

    wb_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (push_data),
        .rdata (fifo_head),
        .full  (unused_fifo_full),
        .empty (fifo_empty),
        .count (fifo_level)
    );

    // Writes are counted when the registered strobe is seen, so DONE follows the last presented write.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (total_words == 32'd0) ? DONE : RUN;
            RUN:     if (push && (accepted + 32'd1 == total)) state_next = DRAIN;
            DRAIN:   if (bram_wen && (written + 32'd1 == total)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            total    <= '0;
            accepted <= '0;
            written  <= '0;
            wr_addr  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN) || (state_next == DRAIN);
            done  <= (state_next == DONE);
            if ((state == IDLE) && start) begin
                total    <= total_words;
                accepted <= '0;
                written  <= '0;
                wr_addr  <= base_addr;
            end else begin
                if (push) begin
                    accepted <= accepted + 32'd1;
                end
                if (bram_wen && ((state == RUN) || (state == DRAIN))) begin
                    written <= written + 32'd1;
                end
                if (pop) begin
                    wr_addr <= wr_addr + 32'(ADDR_STRIDE);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_wen   <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
        end else begin
            bram_wen <= pop;
            if (pop) begin
                bram_addr  <= wr_addr;
                bram_wdata <= fifo_head;
            end
        end
    end

endmodule

// File: doc/mul_wb_packer.md
# mul_wb_packer

Write-back stage downstream of the systolic multiply/adder datapath. Accepts 4-lane × 16-bit result words from the adder output, optionally reduces each lane modulo 2^Q_BITS, buffers them in a small FIFO, and issues sequential 64-bit BRAM writes to the second single-port BRAM port. Arbitration with other BRAM users is handled through a grant input, which gives back-pressure toward the datapath.

## Interface
- DATA_WIDTH, 16: lane width in bits.
- LANES, 4: lanes per word; the word width is DATA_WIDTH*LANES = 64.
- FIFO_DEPTH, 4: buffer entries; must be a power of two, ≥2.
- ADDR_STRIDE, 8: byte-address increment per written word.
- Q_BITS, 15: modulus exponent used by the mask feature; 1 ≤ Q_BITS ≤ DATA_WIDTH.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches base_addr and total_words. Honoured only in IDLE.
- base_addr  in  32  byte address of the first write.
- total_words  in  32  number of 64-bit words in this job.
- in_valid  in  1  in_data is valid.
- in_data  in  64  lanes packed {l3,l2,l1,l0}, with l0 in [15:0].
- in_ready  out  1  the beat is accepted when in_valid && in_ready.
- bram_gnt  in  1  the BRAM port is available in this cycle.
- bram_addr  out  32  write address.
- bram_wen  out  1  write strobe.
- bram_wdata  out  64  write data.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at job completion.

## Operation
- States:
  - IDLE: start → RUN. If total_words==0, start → DONE instead.
  - RUN: when the accepted count reaches total_words → DRAIN.
  - DRAIN: when the written count reaches total_words → DONE.
  - DONE: → IDLE after one cycle. done=1 only in DONE.
- Input acceptance:
  - in_ready = (state==RUN) && fifo_count<FIFO_DEPTH && accepted<total_words.
  - There is no pass-through: a full FIFO deasserts in_ready even if a pop happens in the same cycle.
- Masking (when enabled): each lane is ANDed with (2^Q_BITS−1) before it is pushed.
- Write issue: each cycle in RUN/DRAIN with FIFO non-empty and bram_gnt=1:
  - pop the head;
  - register bram_wen=1, bram_wdata=head, bram_addr=wr_addr;
  - then wr_addr += ADDR_STRIDE (32-bit wrap, no saturation).
- Otherwise bram_wen=0. bram_wdata and bram_addr hold their last values.
- Counters: accepted and written are 32-bit and reset on start.
- start outside IDLE: ignored; no state or counter change.
- in_valid outside RUN: ignored, since in_ready=0.
- Simultaneous push and pop: legal when 0<count<DEPTH; count is unchanged.

## Timing
- Reset values: in_ready=0, bram_wen=0, bram_addr=0, bram_wdata=0, busy=0, done=0. State=IDLE, FIFO empty, counters 0.
- Reset asserted mid-job aborts the job immediately; done is not pulsed.
- All outputs are registered, except in_ready, which is combinational from state and counts.
- Latency: a beat accepted at edge N into an empty FIFO, with bram_gnt=1 in cycle N+1, appears with bram_wen=1 in cycle N+2 (one FIFO cycle plus one output register).
- Throughput: one word per cycle with continuous in_valid and bram_gnt.
- done: asserted the cycle after the registered final write (bram_wen high) is presented.
- bram_gnt low: the FIFO fills. in_ready falls once FIFO_DEPTH entries are held. No data is lost.

## Configuration
- WB_MOD_MASK_EN defined: per-lane mask to Q_BITS as described above.
- WB_MOD_MASK_EN undefined: data passes unmodified and Q_BITS is unused.

## Structure
- Package mul_wb_pkg holds:
  - the state enum typedef wb_state_t {IDLE, RUN, DRAIN, DONE};
  - localparam WORD_W = 64.
- Sub-module wb_fifo, a synchronous FIFO with push/pop/full/empty/count and async active-low reset. It is instantiated once.
- The FSM, counters, mask and output registers live in the top module.

## Test plan
- Basic job: base_addr=0x100, total_words=3, beats 0x0004_0003_0002_0001, 0x…2, 0x…3, bram_gnt=1 → writes to 0x100, 0x108, 0x110 in consecutive cycles; done one cycle after the 3rd write.
- Mask (with WB_MOD_MASK_EN, Q_BITS=15): in_data=0xFFFF_8001_7FFF_8000 → bram_wdata=0x7FFF_0001_7FFF_0000. Without the macro the data is unchanged.
- Back-pressure: bram_gnt=0 for 10 cycles while 6 beats are offered → in_ready drops after 4 accepts. On regrant, all 6 words are written in order with no gaps.
- total_words=0: start → done pulses on the next cycle; no bram_wen.
- start during RUN, with a different base_addr → ignored; addresses continue from the original base.
- rst_n low after 2 of 5 words written → all outputs return to their reset values immediately. A new start then begins a clean job at its own base_addr.
